// File: rtl/mult_seq_if.sv
// Operand/result bundle for the mult_seq shift-add multiplier.
// master = requesting controller, slave = the multiplier.
interface mult_seq_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       a_bi;
    logic [WIDTH-1:0]       b_bi;
    logic                   signed_i;
    logic                   busy_o;
    logic                   done_o;
    logic [2*WIDTH-1:0]     y_bo;

    modport master (
        output start, a_bi, b_bi, signed_i,
        input  busy_o, done_o, y_bo
    );

    modport slave (
        input  start, a_bi, b_bi, signed_i,
        output busy_o, done_o, y_bo
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product after WIDTH+1 clocks.
// Define MULT_SIGNED_EN to honour signed_i (two's-complement operands); otherwise all operations are unsigned.
module mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    mult_seq_if.slave   bus,
    output logic [1:0]  state_o
);
    // Handshake: start is sampled only while busy_o=0; it is then ignored until the
    // one-cycle done_o pulse, during which a new start is accepted again.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]   y_q, y_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       upper;

`ifdef MULT_SIGNED_EN
    logic sign_q, sign_d;
    logic res_sign;

    // Magnitude of the most-negative value is 2^(WIDTH-1), still exact as WIDTH-bit unsigned.
    always_comb begin
        a_mag    = bus.a_bi;
        b_mag    = bus.b_bi;
        res_sign = 1'b0;
        if (bus.signed_i) begin
            if (bus.a_bi[WIDTH-1]) a_mag = -bus.a_bi;
            if (bus.b_bi[WIDTH-1]) b_mag = -bus.b_bi;
            res_sign = bus.a_bi[WIDTH-1] ^ bus.b_bi[WIDTH-1];
        end
    end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = bus.signed_i;
    assign a_mag = bus.a_bi;
    assign b_mag = bus.b_bi;
`endif

    assign sum = acc_q[2*WIDTH:WIDTH] + {1'b0, a_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        y_d     = y_q;
        done_d  = 1'b0;
        upper   = acc_q[2*WIDTH:WIDTH];
`ifdef MULT_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = a_mag;
                    acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
                    cnt_d   = CW'(WIDTH);
`ifdef MULT_SIGNED_EN
                    sign_d  = res_sign;
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Multiplier occupies the low half and is consumed one bit per cycle.
                if (acc_q[0]) upper = sum;
                acc_d = {1'b0, upper, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
`ifdef MULT_SIGNED_EN
                y_d = sign_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
`else
                y_d = acc_q[2*WIDTH-1:0];
`endif
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

`ifdef MULT_SIGNED_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sign_q <= 1'b0;
        else        sign_q <= sign_d;
    end
`endif

    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.done_o = done_q;
    assign bus.y_bo   = y_q;
    assign state_o    = state_q;
endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential shift-add multiplier, the successor to the fixed 16-bit `mult` block. It accepts two WIDTH-bit operands on a start/busy handshake and produces a full 2*WIDTH-bit product after a fixed latency. It adds an optional signed mode and a one-cycle completion pulse. It sits in the datapath as a shared arithmetic unit driven by a controller FSM.

## Interface
- `WIDTH`, default 16: operand width in bits; legal values are 2 or greater.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a_bi`  in  WIDTH  multiplicand.
- `b_bi`  in  WIDTH  multiplier.
- `signed_i`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `busy_o`  out  1  high while a multiplication is in progress.
- `done_o`  out  1  one-cycle pulse when `y_bo` updates.
- `y_bo`  out  2*WIDTH  product; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - On a clock edge with `start`=1: latch operands and the sign mode, clear the accumulator, load the iteration counter with WIDTH, go to CALC.
  - In signed mode, latch operand magnitudes plus the result sign (XOR of the operand MSBs).
  - In unsigned mode, latch operands as-is with result sign 0.
- **CALC**
  - Each cycle: if multiplier LSB is 1, add the multiplicand to the upper half of the accumulator.
  - Then shift the accumulator/multiplier right by 1, carry included; accumulator width is 2*WIDTH+1 internally.
  - Decrement the counter. When the counter reaches 1 on this cycle, go to FIX.
- **FIX**
  - Load `y_bo` with the accumulator, two's-complement negated if the result sign is set.
  - Pulse `done_o`, go to IDLE.
- Magnitude of the most-negative operand is WIDTH-bit unsigned 2^(WIDTH-1). It is handled exactly, with no overflow: the full product always fits in 2*WIDTH bits.
- `start` while `busy_o`=1: ignored. No queueing, and the operands in flight are unaffected.
- Operand and mode inputs are don't-care outside the `start` sample edge.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `y_bo`=0, state IDLE, counter 0. Reset takes effect immediately and asynchronously.
- Reset mid-operation aborts the operation. No `done_o` is produced and `y_bo` is forced to 0.
- Edge E samples `start`=1. `busy_o` is 1 from E through E+WIDTH, i.e. WIDTH+1 cycles.
- At edge E+WIDTH+1, `y_bo` takes the new product, `done_o`=1 for exactly one cycle, and `busy_o`=0.
- Total latency from the `start` edge to a valid `y_bo` is WIDTH+1 clocks.
- Back-to-back: `start`=1 during the `done_o` cycle is accepted, because the state is IDLE. Throughput is one product per WIDTH+1 cycles.
- `y_bo` changes only at FIX exit or on reset.

## Configuration
- `MULT_SIGNED_EN` defined: `signed_i` is honoured as described.
- `MULT_SIGNED_EN` undefined:
  - The `signed_i` port remains but is ignored; all operations are unsigned.
  - The sign-handling logic (magnitude conversion, result negation) is not synthesised.
  - Latency is unchanged, and FIX is kept as a pass-through load cycle.

## Test plan
All scenarios use WIDTH=16.
1. Reset asserted low with random inputs -> `busy_o`=0, `done_o`=0, `y_bo`=0.
2. Unsigned, a=8, b=8, `start` pulse at edge E -> `busy_o` high for 17 cycles; at E+17, `y_bo`=32'h0000_0040 with a one-cycle `done_o`.
3. Unsigned, a=16'hFFFF, b=16'hFFFF -> `y_bo`=32'hFFFE_0001.
4. Signed with `MULT_SIGNED_EN` defined:
   - a=-3, b=5 -> `y_bo`=32'hFFFF_FFF1.
   - a=b=16'h8000 -> `y_bo`=32'h4000_0000.
   - Same stimulus with the macro undefined -> unsigned products 32'h0004_FFF1 and 32'h4000_0000.
5. `start` re-asserted with new operands during `busy_o` -> the first result is unchanged and no extra `done_o`. A `start` during the `done_o` cycle -> a second result 17 cycles later.
6. `reset` pulsed low at CALC cycle 8 -> immediate IDLE with `y_bo`=0 and no `done_o`. A subsequent 7*9 -> 32'h0000_003F.
